// File: rtl/life_pkg.sv
// Shared types and rule constants for the Game of Life grid.
// Rule masks are indexed by live-neighbour count (0..8).
package life_pkg;

   localparam int GEN_W = 16;

   // B3/S23: born with exactly 3, survives with 2 or 3
   localparam logic [8:0] BIRTH   = 9'b0_0000_1000;
   localparam logic [8:0] SURVIVE = 9'b0_0000_1100;

   typedef enum logic [1:0] {
      IDLE,
      STEP,
      COUNT
   } state_t;

endpackage

// File: rtl/life_cell_next.sv
// Next-state rule for one cell, given its eight neighbours.
// Purely combinational; one instance per grid cell.
module life_cell_next
   import life_pkg::*;
(
   input  logic       alive,
   input  logic [7:0] nbrs,
   output logic       next
);

   logic [3:0] cnt;

   always_comb begin
      cnt = '0;
      for (int i = 0; i < 8; i++) begin
         cnt = cnt + {3'b000, nbrs[i]};
      end
   end

   assign next = alive ? SURVIVE[cnt] : BIRTH[cnt];

endmodule

// File: rtl/life_array_grid.sv
// ROWS x COLS Game of Life array: one-cycle generation step,
// then a row-serial population count over ROWS cycles.
module life_array_grid
   import life_pkg::*;
#(
   parameter int ROWS = 8,
   parameter int COLS = 8,
   parameter int WRAP = 1,
   localparam int RW = $clog2(ROWS),
   localparam int PW = $clog2(ROWS * COLS + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             write_enb,
   input  logic [RW-1:0]    wr_row,
   input  logic [COLS-1:0]  vali,
   input  logic [RW-1:0]    rd_row,
   output logic [COLS-1:0]  valo,
   output logic [COLS-1:0]  valo_prev,
   input  logic             step,
   output logic             busy,
   output logic             done,
   output logic [GEN_W-1:0] generation,
   output logic [PW-1:0]    population,
   output logic             stable
);

   logic [COLS-1:0]      cur  [ROWS];
   logic [COLS-1:0]      prev [ROWS];
   logic [ROWS*COLS-1:0] nxt;

   state_t        state_q;
   state_t        state_d;
   logic [RW-1:0] row_q;
   logic [PW-1:0] acc_q;
   logic [PW-1:0] sum;
   logic          do_write;
   logic          do_step;
   logic          last;
   logic          same;
   logic          rd_ok;
   logic          wr_ok;

   // Neighbour k order: NW, N, NE, W, E, SW, S, SE
   for (genvar r = 0; r < ROWS; r++) begin : g_r
      for (genvar c = 0; c < COLS; c++) begin : g_c
         logic [7:0] nb;
         for (genvar k = 0; k < 8; k++) begin : g_k
            localparam int DR = (k < 3) ? -1 : ((k < 5) ? 0 : 1);
            localparam int DC = (k == 0 || k == 3 || k == 5) ? -1 :
                                ((k == 1 || k == 6) ? 0 : 1);
            localparam int NR = r + DR;
            localparam int NC = c + DC;
            localparam int RR = (NR + ROWS) % ROWS;
            localparam int CC = (NC + COLS) % COLS;
            if (WRAP != 0 || (NR >= 0 && NR < ROWS &&
                              NC >= 0 && NC < COLS)) begin : g_in
               assign nb[k] = cur[RR][CC];
            end else begin : g_out
               assign nb[k] = 1'b0;
            end
         end
         life_cell_next u_cell (
            .alive (cur[r][c]),
            .nbrs  (nb),
            .next  (nxt[r*COLS+c])
         );
      end
   end

   assign rd_ok     = int'(rd_row) < ROWS;
   assign wr_ok     = int'(wr_row) < ROWS;
   assign valo      = rd_ok ? cur[rd_row] : '0;
   assign valo_prev = rd_ok ? prev[rd_row] : '0;
   assign busy      = state_q != IDLE;
   assign sum       = acc_q + PW'($countones(cur[row_q]));

   always_comb begin
      same = 1'b1;
      for (int r = 0; r < ROWS; r++) begin
         if (cur[r] != prev[r]) same = 1'b0;
      end
   end

   always_comb begin
      state_d  = state_q;
      do_write = 1'b0;
      do_step  = 1'b0;
      last     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (write_enb) begin
               do_write = wr_ok;
            end else if (step) begin
               state_d = STEP;
            end
         end
         STEP: begin
            do_step = 1'b1;
            state_d = COUNT;
         end
         COUNT: begin
            if (row_q == RW'(ROWS - 1)) begin
               last    = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         row_q      <= '0;
         acc_q      <= '0;
         generation <= '0;
         population <= '0;
         stable     <= 1'b0;
         done       <= 1'b0;
         for (int r = 0; r < ROWS; r++) begin
            cur[r]  <= '0;
            prev[r] <= '0;
         end
      end else begin
         state_q <= state_d;
         done    <= last;
         if (do_write) cur[wr_row] <= vali;
         if (do_step) begin
            acc_q <= '0;
            row_q <= '0;
            for (int r = 0; r < ROWS; r++) begin
               cur[r]  <= nxt[r*COLS +: COLS];
               prev[r] <= cur[r];
            end
         end
         if (state_q == COUNT) begin
            acc_q <= sum;
            row_q <= row_q + 1'b1;
            if (last) begin
               row_q      <= '0;
               population <= sum;
               generation <= generation + 1'b1;
               stable     <= same;
            end
         end
      end
   end

endmodule
